vector_sequencer: RTL and testbench
===================================

Name: vector_sequencer

Overview:
Program sequencer for the vector ASIP decode stage. It fetches 32-bit instructions from a synchronous instruction memory and presents them one at a time to control_unit. It maintains the vector length N, loaded by SETN, and the pixel counters i and j, advanced by INCRI and INCRJ. It re-runs the kernel program from address 0 until i reaches N.

Parameters:
ADDR_W, 8, instruction memory address width (program depth 2^ADDR_W words)
N_W, 16, width of n_reg, i_count and j_count
NOP_WORD, 32'h5000_0000, instruction driven on instr_out when no instruction is issued

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts the program (honoured only in IDLE)
dp_stall  in  1  datapath stall; holds the current issued instruction
imem_data  in  32  instruction memory read data, valid 1 cycle after imem_rd_en
imem_addr  out  ADDR_W  instruction memory address (current PC)
imem_rd_en  out  1  instruction memory read strobe
instr_out  out  32  instruction to control_unit
instr_valid  out  1  instr_out holds a real instruction this cycle
n_reg  out  N_W  vector length set by SETN
i_count  out  N_W  pixel counter i
j_count  out  N_W  pixel counter j
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at normal program completion
err  out  1  sticky; PC ran off the end of memory; cleared by start

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous, active-high.
- Values after reset: state=IDLE, PC=0, all outputs 0 except instr_out=NOP_WORD.
- Opcode field: instr[31:28].
  - 0000 INCRI, 0001 INCRJ, 0010 SETN (immediate instr[N_W-1:0]), 0011 SUMFV, 0100 MULFV, 0101 NOP, 0110 LDV.
  - 1111 HALT: sequencer-only, never issued.
  - Any other opcode is issued unchanged.
- States: IDLE, FETCH, EXEC, DONE (plus BUBBLE, present only when the optional feature is enabled).
- IDLE -> FETCH on start.
  - Same edge: PC<=0, i_count<=0, j_count<=0, n_reg<=0, err<=0.
  - imem_rd_en=1 during the start cycle.
- FETCH, 1 cycle: waits for the read data, then -> EXEC.
- EXEC, non-HALT opcode:
  - instr_out=imem_data and instr_valid=1.
  - While dp_stall=1: stay in EXEC; outputs held; no counter or PC update.
  - With dp_stall=0, on the leaving edge:
    - SETN: n_reg<=imm.
    - INCRI: i_count<=i_count+1, modulo 2^N_W.
    - INCRJ: j_count<=j_count+1, modulo 2^N_W.
    - PC<=PC+1, imem_rd_en=1 this cycle, -> FETCH.
- EXEC, HALT opcode: instr_valid=0, dp_stall ignored.
  - If i_count < n_reg: PC<=0, read issued, -> FETCH. The next kernel pass starts; i, j and n are kept.
  - Else: -> DONE. N=0 therefore ends at the first HALT.
- EXEC at PC=2^ADDR_W-1 with a non-HALT opcode: the instruction is issued normally. On leaving, err<=1 and -> DONE, with no wrap to 0.
- DONE, 1 cycle: done=1 only if err=0, then -> IDLE.
- Throughput: 2 cycles per instruction, with instruction valid 2 cycles after its read strobe.
- start outside IDLE is ignored. start in the DONE cycle is ignored.
- rst mid-program: immediate return to reset values; instr_valid drops asynchronously.
- instr_out=NOP_WORD whenever instr_valid=0.

Optional Feature:
Macro VSEQ_HAZARD_NOP_EN.
- Defined: a register remembers whether the last issued instruction was MULFV.
  - If the instruction entering EXEC is SUMFV and it directly follows an issued MULFV, the sequencer passes through BUBBLE for one cycle first. BUBBLE drives instr_valid=0 and instr_out=NOP_WORD.
  - The remembered flag is cleared on start and on HALT loop-back.
- Undefined: no BUBBLE state; SUMFV is issued like any other instruction.

Test Plan:
- Program {SETN 400 (0x2000_0190), INCRI, HALT}, start pulse -> n_reg=400, and done pulses once after exactly 400 kernel passes with i_count=400. Per pass: three EXEC cycles, instr_valid high in two of them.
- Program {INCRJ, HALT}, n_reg=0 -> single pass, j_count=1, done pulses 5 cycles after start, busy low the following cycle.
- Program {SETN 2, LDV 1 (0x6800_0000), INCRI, HALT} with dp_stall held high 3 cycles during LDV -> instr_out=0x6800_0000 with instr_valid=1 for 4 consecutive cycles, and i_count unchanged until the stall releases.
- Memory with no HALT, ADDR_W=4 -> 16 instructions issued, err=1, done never pulses, busy falls. A following start clears err.
- rst asserted mid-EXEC of MULFV (0x4C00_0000) -> same-cycle instr_valid=0, instr_out=0x5000_0000, state IDLE. A start pulse during the program (not IDLE) has no effect.
- VSEQ_HAZARD_NOP_EN defined, program {MULFV, SUMFV, HALT} -> exactly one instr_valid=0 cycle beyond the normal gap between MULFV and SUMFV. Undefined -> no extra cycle.

Source files
------------

// File: rtl/vector_sequencer.sv
// Program sequencer for the vector ASIP decode stage: fetches, issues and loops the kernel program.
// Optional macro VSEQ_HAZARD_NOP_EN inserts a one-cycle bubble before a SUMFV that follows a MULFV.
module vector_sequencer #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned N_W      = 16,
   parameter logic [31:0] NOP_WORD = 32'h5000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              dp_stall,
   input  logic [31:0]       imem_data,
   output logic [ADDR_W-1:0] imem_addr,
   output logic              imem_rd_en,
   output logic [31:0]       instr_out,
   output logic              instr_valid,
   output logic [N_W-1:0]    n_reg,
   output logic [N_W-1:0]    i_count,
   output logic [N_W-1:0]    j_count,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [3:0] OP_INCRI = 4'h0;
   localparam logic [3:0] OP_INCRJ = 4'h1;
   localparam logic [3:0] OP_SETN  = 4'h2;
   localparam logic [3:0] OP_HALT  = 4'hF;
`ifdef VSEQ_HAZARD_NOP_EN
   localparam logic [3:0] OP_SUMFV = 4'h3;
   localparam logic [3:0] OP_MULFV = 4'h4;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_DONE
`ifdef VSEQ_HAZARD_NOP_EN
      , S_BUBBLE
`endif
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                rd_en_d;
   logic                halt_q;
   logic [31:0]         instr_out_q;
   logic                instr_valid_q;
   logic [N_W-1:0]      n_q, i_q, j_q;
   logic                busy_q, done_q, err_q;
`ifdef VSEQ_HAZARD_NOP_EN
   logic                last_mul_q;
   logic [31:0]         hold_q;
`endif

   logic [3:0] ex_op;
   logic       loop_back;
   logic       pc_last;

   // The issued instruction register doubles as the decode source in EXEC.
   assign ex_op     = instr_out_q[31:28];
   assign loop_back = (i_q < n_q);
   assign pc_last   = &pc_q;

   // Next fetch address is presented combinationally so the read lands in FETCH.
   always_comb begin
      pc_d    = pc_q;
      rd_en_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               pc_d    = '0;
               rd_en_d = 1'b1;
            end
         end
         S_EXEC: begin
            if (halt_q) begin
               if (loop_back) begin
                  pc_d    = '0;
                  rd_en_d = 1'b1;
               end
            end else if (!dp_stall && !pc_last) begin
               pc_d    = pc_q + ADDR_W'(1);
               rd_en_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         halt_q        <= 1'b0;
         instr_out_q   <= NOP_WORD;
         instr_valid_q <= 1'b0;
         n_q           <= '0;
         i_q           <= '0;
         j_q           <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
`ifdef VSEQ_HAZARD_NOP_EN
         last_mul_q    <= 1'b0;
         hold_q        <= NOP_WORD;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  state_q <= S_FETCH;
                  pc_q    <= pc_d;
                  n_q     <= '0;
                  i_q     <= '0;
                  j_q     <= '0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
`ifdef VSEQ_HAZARD_NOP_EN
                  last_mul_q <= 1'b0;
`endif
               end
            end
            S_FETCH: begin
               state_q       <= S_EXEC;
               halt_q        <= (imem_data[31:28] == OP_HALT);
               instr_valid_q <= (imem_data[31:28] != OP_HALT);
               instr_out_q   <= (imem_data[31:28] != OP_HALT) ? imem_data : NOP_WORD;
`ifdef VSEQ_HAZARD_NOP_EN
               if ((imem_data[31:28] == OP_SUMFV) && last_mul_q) begin
                  state_q       <= S_BUBBLE;
                  hold_q        <= imem_data;
                  instr_valid_q <= 1'b0;
                  instr_out_q   <= NOP_WORD;
               end
`endif
            end
`ifdef VSEQ_HAZARD_NOP_EN
            S_BUBBLE: begin
               state_q       <= S_EXEC;
               instr_valid_q <= 1'b1;
               instr_out_q   <= hold_q;
            end
`endif
            S_EXEC: begin
               if (halt_q) begin
                  if (loop_back) begin
                     state_q <= S_FETCH;
                     pc_q    <= pc_d;
`ifdef VSEQ_HAZARD_NOP_EN
                     last_mul_q <= 1'b0;
`endif
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= ~err_q;
                  end
               end else if (!dp_stall) begin
                  instr_valid_q <= 1'b0;
                  instr_out_q   <= NOP_WORD;
                  case (ex_op)
                     OP_SETN:  n_q <= instr_out_q[N_W-1:0];
                     OP_INCRI: i_q <= i_q + N_W'(1);
                     OP_INCRJ: j_q <= j_q + N_W'(1);
                     default: ;
                  endcase
`ifdef VSEQ_HAZARD_NOP_EN
                  last_mul_q <= (ex_op == OP_MULFV);
`endif
                  // Running past the last word is an error; no wrap to address 0.
                  if (pc_last) begin
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     pc_q    <= pc_d;
                     state_q <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign imem_addr   = pc_d;
   assign imem_rd_en  = rd_en_d;
   assign instr_out   = instr_out_q;
   assign instr_valid = instr_valid_q;
   assign n_reg       = n_q;
   assign i_count     = i_q;
   assign j_count     = j_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: program table with end-state checks, an
// instruction-level scoreboard of issued words, and hand sequences for timing corner cases.
module tb_vector_sequencer;

   localparam int unsigned AW = 4;
   localparam int unsigned NW = 16;
   localparam logic [31:0] NOP     = 32'h5000_0000;
   localparam logic [31:0] I_INCRI = 32'h0000_0000;
   localparam logic [31:0] I_INCRJ = 32'h1000_0000;
   localparam logic [31:0] I_SUMFV = 32'h3000_0000;
   localparam logic [31:0] I_MULFV = 32'h4C00_0000;
   localparam logic [31:0] I_LDV   = 32'h6800_0000;
   localparam logic [31:0] I_ODD   = 32'h7123_4567;
   localparam logic [31:0] I_HALT  = 32'hF000_0000;

   logic          clk = 1'b0;
   logic          rst, start, dp_stall;
   logic [31:0]   imem_data;
   logic [AW-1:0] imem_addr;
   logic          imem_rd_en;
   logic [31:0]   instr_out;
   logic          instr_valid;
   logic [NW-1:0] n_reg, i_count, j_count;
   logic          busy, done, err;

   vector_sequencer #(.ADDR_W(AW), .N_W(NW), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .start(start), .dp_stall(dp_stall),
      .imem_data(imem_data), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
      .instr_out(instr_out), .instr_valid(instr_valid),
      .n_reg(n_reg), .i_count(i_count), .j_count(j_count),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [16];
   always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

   typedef struct {
      int prog;
      int exp_n;
      int exp_i;
      int exp_j;
      int exp_err;
      int exp_dones;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] exp_q [$];
   int          vectors = 0;
   int          miscompares = 0;
   int          done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: an instruction retires on a valid cycle with no stall.
   always @(negedge clk) begin
      #1;
      if (done === 1'b1) done_cnt++;
      if (instr_valid === 1'b1 && dp_stall === 1'b0) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_underflow: issued %h with nothing expected", instr_out);
         end else begin
            chk("sb_issue", instr_out, exp_q.pop_front());
         end
      end else if (instr_valid === 1'b0 && instr_out !== NOP) begin
         chk("nop_when_invalid", instr_out, NOP);
      end
   end

   task automatic load_prog(input int p);
      for (int k = 0; k < 16; k++) mem[k] = I_HALT;
      case (p)
         0: begin mem[0] = 32'h2000_0190; mem[1] = I_INCRI; end
         1: begin mem[0] = I_INCRJ; end
         2: begin mem[0] = 32'h2000_0002; mem[1] = I_LDV; mem[2] = I_INCRI; end
         3: for (int k = 0; k < 16; k++) mem[k] = I_INCRJ;
         4: begin mem[0] = I_MULFV; mem[1] = I_SUMFV; end
         5: begin mem[0] = 32'h2000_0003; mem[1] = I_INCRI; mem[2] = I_INCRJ; mem[3] = I_ODD; end
         default: for (int k = 0; k < 15; k++) mem[k] = I_INCRJ;
      endcase
   endtask

   // Instruction-level model: pushes the expected issue stream for the loaded program.
   task automatic model_prog();
      logic [3:0]  pc;
      logic [15:0] n, i;
      logic [31:0] w;
      pc = '0; n = '0; i = '0;
      exp_q.delete();
      for (int s = 0; s < 10000; s++) begin
         w = mem[pc];
         if (w[31:28] == 4'hF) begin
            if (i < n) pc = '0;
            else break;
         end else begin
            exp_q.push_back(w);
            if (w[31:28] == 4'h2) n = w[15:0];
            if (w[31:28] == 4'h0) i = i + 16'd1;
            if (pc == 4'hF) break;
            pc = pc + 4'd1;
         end
      end
   endtask

   task automatic start_prog(input int p);
      load_prog(p);
      model_prog();
      done_cnt = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int c;
      for (c = 0; c < 5000; c++) begin
         if (busy === 1'b0) break;
         @(negedge clk);
      end
      if (c == 5000) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: busy still %b after %0d cycles", name, busy, c);
      end
      @(negedge clk);
      chk({name, "_sb_drain"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_issue(input logic [31:0] w, input string name);
      int c;
      for (c = 0; c < 200; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1 && instr_out === w) break;
      end
      if (c == 200) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_wait: %h never issued", name, w);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_done, cnt, gap;
      rst = 1'b1; start = 1'b0; dp_stall = 1'b0;
      for (int k = 0; k < 16; k++) mem[k] = I_HALT;
      vecs[0] = '{0, 400, 400, 0, 0, 1};
      vecs[1] = '{1, 0, 0, 1, 0, 1};
      vecs[2] = '{3, 0, 0, 16, 1, 0};
      vecs[3] = '{5, 3, 3, 3, 0, 1};
      vecs[4] = '{6, 0, 0, 15, 0, 1};
      vecs[5] = '{4, 0, 0, 0, 0, 1};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_instr_out", instr_out, NOP);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_counters", {n_reg, i_count | j_count}, 32'd0);
      chk("rst_rd_en", 32'(imem_rd_en), 32'd0);
      chk("rst_addr", 32'(imem_addr), 32'd0);

      for (int v = 0; v < 6; v++) begin
         start_prog(vecs[v].prog);
         wait_idle("prog");
         chk("n_reg", 32'(n_reg), vecs[v].exp_n);
         chk("i_count", 32'(i_count), vecs[v].exp_i);
         chk("j_count", 32'(j_count), vecs[v].exp_j);
         chk("err", 32'(err), vecs[v].exp_err);
         chk("done_pulses", 32'(done_cnt), vecs[v].exp_dones);
      end

      // Start-to-done latency, with start pulses in EXEC and DONE that must be ignored.
      load_prog(1); model_prog(); done_cnt = 0; first_done = -1;
      @(negedge clk); start = 1'b1;
      #1;
      chk("start_rd_en", 32'(imem_rd_en), 32'd1);
      chk("start_addr", 32'(imem_addr), 32'd0);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (done === 1'b1 && first_done < 0) first_done = k;
         if (k == 1 || k == 3 || k == 6) start = 1'b0;
         if (k == 2) start = 1'b1;
         if (k == 5) begin
            start = 1'b1;
            #1;
            chk("done_cycle_rd_en", 32'(imem_rd_en), 32'd0);
         end
         if (k == 6) chk("busy_after_done", 32'(busy), 32'd0);
      end
      chk("done_latency", first_done, 32'd5);
      wait_idle("latency");
      chk("latency_dones", 32'(done_cnt), 32'd1);

      // LDV held by a three-cycle datapath stall.
      start_prog(2);
      wait_issue(I_LDV, "ldv");
      dp_stall = 1'b1;
      cnt = 1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (instr_valid === 1'b1 && instr_out === I_LDV) cnt++;
         chk("stall_i_hold", 32'(i_count), 32'd0);
         if (k == 3) dp_stall = 1'b0;
      end
      chk("stall_valid_cycles", cnt, 32'd4);
      wait_idle("stall");
      chk("stall_i_final", 32'(i_count), 32'd2);

      // Reset in the middle of an issued MULFV.
      start_prog(4);
      wait_issue(I_MULFV, "mulfv");
      rst = 1'b1;
      #1;
      chk("midrst_valid", 32'(instr_valid), 32'd0);
      chk("midrst_instr_out", instr_out, NOP);
      chk("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();

      // Gap between MULFV and SUMFV: one bubble cycle more with the hazard option.
      start_prog(4);
      wait_issue(I_MULFV, "haz");
      gap = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (instr_valid === 1'b1) break;
         gap++;
      end
      chk("haz_next_issue", instr_out, I_SUMFV);
`ifdef VSEQ_HAZARD_NOP_EN
      chk("haz_gap", gap, 32'd2);
`else
      chk("haz_gap", gap, 32'd1);
`endif
      wait_idle("haz");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
